enemy_draw_scheduler: RTL and testbench
=======================================

Name: enemy_draw_scheduler

Overview:
- Shares the single vector-draw engine (ROM walker feeding the X/Y DACs) among N enemy sprites once per display frame.
- On each frame tick it walks the spawned enemies in round-robin order and issues one draw job per enemy (sprite base address plus x offset). It waits for the engine's completion before issuing the next job.
- Sits between game_logic_top (enemy spawn/x/adr outputs) and the vector draw engine.

Parameters:
- N_ENEMIES, 3, number of requesters (enemy slots).
- DAC_WIDTH, 8, x offset width (matches vector_pkg).
- ADDRESSWIDTH, 16, sprite ROM address width (matches img_pkg).
- TIMEOUT_CYCLES, 4096, watchdog limit per draw job; used only with DRAW_TIMEOUT_EN.

Ports:
- clk  in  1  draw-domain clock (40 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  single-cycle pulse at frame boundary.
- spawn  in  N_ENEMIES  bit i high = enemy i alive and must be drawn.
- x_in  in  N_ENEMIES*DAC_WIDTH  packed x offsets; slot i at [i*DAC_WIDTH +: DAC_WIDTH].
- adr_in  in  N_ENEMIES*ADDRESSWIDTH  packed sprite base addresses.
- draw_start  out  1  single-cycle job strobe to the engine.
- draw_x  out  DAC_WIDTH  x offset of the current job; held stable from draw_start to draw_done.
- draw_adr  out  ADDRESSWIDTH  base address of the current job; held stable likewise.
- draw_sel  out  $clog2(N_ENEMIES)  index of the current job.
- draw_done  in  1  single-cycle pulse from the engine at job end.
- busy  out  1  high from frame acceptance until the frame ends.
- frame_done  out  1  single-cycle pulse after the last job of a frame.
- overrun_cnt  out  8  saturating count of frames aborted by a new frame_start.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs are 0: draw_start, draw_x, draw_adr, draw_sel, busy, frame_done, overrun_cnt. rr_ptr=0.
- States: IDLE, SCAN, ISSUE, WAIT, FINISH.
- IDLE:
  - frame_start=1 -> latch spawn into pending mask, set busy=1, go to SCAN.
  - If the latched mask is 0, SCAN goes straight to FINISH.
- SCAN: pick the lowest set pending bit at or above rr_ptr, wrapping modulo N_ENEMIES.
  - Register sel plus that slot's x/adr sampled this cycle.
  - Clear the pending bit, go to ISSUE.
- ISSUE: draw_start=1 for exactly one cycle, go to WAIT.
  - Latency: frame_start in cycle t -> draw_start in cycle t+2.
- WAIT: draw_done=1 -> if pending≠0 go to SCAN, else go to FINISH.
  - A draw_done that arrives in the same cycle as draw_start is ignored. The engine must take at least 1 cycle.
- FINISH: frame_done=1 for one cycle, busy=0, rr_ptr=(rr_ptr+1) mod N_ENEMIES, go to IDLE.
- Fairness: the start index rotates by one each completed frame, so the drawing order is rotated.
- Spawn changes mid-frame are ignored; the mask is latched at frame_start.
  - x/adr are sampled per job at SCAN, so positions are as fresh as possible.
- frame_start while busy (SCAN/ISSUE/WAIT):
  - Abort the current frame; overrun_cnt+1, saturating at 255.
  - No frame_done pulse; rr_ptr is not advanced.
  - Relatch spawn, go to SCAN.
  - The in-flight engine job is abandoned: draw_x/draw_adr may change only after the new draw_start.
- frame_start coincident with draw_done in WAIT: abort takes priority; treated as overrun.
- frame_start in FINISH: frame_done still pulses, then frame_start is accepted as in IDLE (no overrun).
- draw_done outside WAIT: ignored.
- rst_n assertion mid-job: immediate return to reset values; engine reset is the engine's responsibility.

Optional Feature:
- Macro DRAW_TIMEOUT_EN.
- Defined: a watchdog counter clears at ISSUE and counts in WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without draw_done, the job is abandoned and the FSM proceeds as if draw_done arrived.
  - A sticky output timeout_flag (1 bit, reset 0, cleared only by reset) is set.
- Undefined: no counter and no timeout_flag port; WAIT holds indefinitely.

Decomposition:
- vector_pkg additions: N_ENEMIES constant and a sched_state_t enum (IDLE, SCAN, ISSUE, WAIT, FINISH).
- DAC_WIDTH stays in vector_pkg; ADDRESSWIDTH stays in img_pkg.
- One sub-module, rr_pick: combinational round-robin picker. Inputs: pending mask and rr_ptr. Outputs: index and valid.
  - Instantiated once; unit-testable on its own.

Test Plan:
1. spawn=3'b111, x_in={30,20,10}, adr_in={0x300,0x200,0x100}, frame_start, engine done 5 cycles after each start -> jobs in order sel 0,1,2 with x=10,20,30 and adr 0x100/0x200/0x300; first draw_start 2 cycles after frame_start; one frame_done; busy low after.
2. Three consecutive frames with spawn=3'b111 -> start order 0,1,2 then 1,2,0 then 2,0,1.
3. spawn=3'b101 -> only sel 0 and 2 drawn. spawn=0 -> frame_done 2 cycles after frame_start, no draw_start.
4. frame_start re-asserted while in WAIT on sel 1 -> overrun_cnt=1, no frame_done, new draw_start 2 cycles later; 300 forced overruns -> overrun_cnt=255.
5. rst_n low during WAIT -> all outputs 0 asynchronously; after release a new frame_start restarts at sel 0.
6. With DRAW_TIMEOUT_EN and TIMEOUT_CYCLES=16, the engine never answers sel 0 -> sel 1 draw_start 18 cycles after sel 0 draw_start; timeout_flag=1.

Source files
------------

// File: rtl/enemy_draw_scheduler_pkg.sv
// Shared constants and state type for the enemy draw scheduler.
// Slot count, DAC/ROM widths and the scheduler FSM encoding.
package enemy_draw_scheduler_pkg;

    localparam int N_ENEMIES    = 3;
    localparam int DAC_WIDTH    = 8;
    localparam int ADDRESSWIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        ISSUE,
        WAIT,
        FINISH
    } sched_state_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/enemy_draw_scheduler_rr_pick.sv
// Round-robin picker: lowest pending slot at or above ptr_i,
// wrapping modulo N. Purely combinational.
module rr_pick
    import enemy_draw_scheduler_pkg::*;
#(
    parameter int N = N_ENEMIES,
    localparam int SW = sel_width(N)
) (
    input  logic [N-1:0]  pending_i,
    input  logic [SW-1:0] ptr_i,
    output logic [SW-1:0] idx_o,
    output logic          valid_o
);

    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        int j;
        j       = 0;
        idx_o   = '0;
        valid_o = |pending_i;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % N;
            if (pending_i[j]) idx_o = SW'(j);
        end
    end

endmodule

// File: rtl/enemy_draw_scheduler.sv
// Shares the vector draw engine among enemy slots once per frame.
// Optional DRAW_TIMEOUT_EN adds a per-job watchdog and timeout_flag.
module enemy_draw_scheduler #(
    parameter int N_ENEMIES    = enemy_draw_scheduler_pkg::N_ENEMIES,
    parameter int DAC_WIDTH    = enemy_draw_scheduler_pkg::DAC_WIDTH,
    parameter int ADDRESSWIDTH = enemy_draw_scheduler_pkg::ADDRESSWIDTH,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int SW = enemy_draw_scheduler_pkg::sel_width(N_ENEMIES)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           frame_start,
    input  logic [N_ENEMIES-1:0]           spawn,
    input  logic [N_ENEMIES*DAC_WIDTH-1:0] x_in,
    input  logic [N_ENEMIES*ADDRESSWIDTH-1:0] adr_in,
    output logic                           draw_start,
    output logic [DAC_WIDTH-1:0]           draw_x,
    output logic [ADDRESSWIDTH-1:0]        draw_adr,
    output logic [SW-1:0]                  draw_sel,
    input  logic                           draw_done,
    output logic                           busy,
    output logic                           frame_done,
    output logic [7:0]                     overrun_cnt
`ifdef DRAW_TIMEOUT_EN
    ,
    output logic                           timeout_flag
`endif
);

    import enemy_draw_scheduler_pkg::*;

    sched_state_t              state_q;
    logic [N_ENEMIES-1:0]      pending_q;
    logic [SW-1:0]             rr_ptr_q;
    logic [SW-1:0]             sel_q;
    logic [SW-1:0]             pick_idx;
    logic                      pick_valid;
    logic [DAC_WIDTH-1:0]      x_q;
    logic [ADDRESSWIDTH-1:0]   adr_q;
    logic                      start_q;
    logic                      busy_q;
    logic                      fdone_q;
    logic [7:0]                ovr_q;
    logic                      abort;
    logic                      job_end;

    rr_pick #(.N(N_ENEMIES)) u_pick (
        .pending_i (pending_q),
        .ptr_i     (rr_ptr_q),
        .idx_o     (pick_idx),
        .valid_o   (pick_valid)
    );

    assign abort = frame_start && (state_q inside {SCAN, ISSUE, WAIT});

`ifdef DRAW_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES);

    logic [WDW-1:0] wd_q;
    logic           tflag_q;
    logic           wd_hit;

    assign wd_hit  = (state_q == WAIT) && (wd_q == WDW'(TIMEOUT_CYCLES - 1));
    assign job_end = draw_done || wd_hit;

    // Watchdog: cleared while the job is issued, counts while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q    <= '0;
            tflag_q <= 1'b0;
        end else if (state_q == ISSUE) begin
            wd_q <= '0;
        end else if (state_q == WAIT) begin
            wd_q <= wd_q + 1'b1;
            if (wd_hit && !draw_done && !frame_start) tflag_q <= 1'b1;
        end
    end

    assign timeout_flag = tflag_q;
`else
    assign job_end = draw_done;
`endif

    // Frame FSM: latch mask, pick, strobe, wait, report; abort on re-trigger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            rr_ptr_q  <= '0;
            sel_q     <= '0;
            x_q       <= '0;
            adr_q     <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            fdone_q   <= 1'b0;
            ovr_q     <= '0;
        end else begin
            start_q <= 1'b0;
            fdone_q <= 1'b0;
            if (abort) begin
                pending_q <= spawn;
                state_q   <= SCAN;
                if (ovr_q != 8'hFF) ovr_q <= ovr_q + 8'd1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (frame_start) begin
                            pending_q <= spawn;
                            busy_q    <= 1'b1;
                            state_q   <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (pick_valid) begin
                            sel_q   <= pick_idx;
                            x_q     <= x_in[pick_idx*DAC_WIDTH +: DAC_WIDTH];
                            adr_q   <= adr_in[pick_idx*ADDRESSWIDTH +: ADDRESSWIDTH];
                            pending_q[pick_idx] <= 1'b0;
                            start_q <= 1'b1;
                            state_q <= ISSUE;
                        end else begin
                            fdone_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= FINISH;
                        end
                    end
                    ISSUE: state_q <= WAIT;
                    WAIT: begin
                        if (job_end) begin
                            if (|pending_q) begin
                                state_q <= SCAN;
                            end else begin
                                fdone_q <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= FINISH;
                            end
                        end
                    end
                    FINISH: begin
                        rr_ptr_q <= (rr_ptr_q == SW'(N_ENEMIES - 1)) ?
                                    '0 : rr_ptr_q + 1'b1;
                        if (frame_start) begin
                            pending_q <= spawn;
                            busy_q    <= 1'b1;
                            state_q   <= SCAN;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign draw_start  = start_q;
    assign draw_x      = x_q;
    assign draw_adr    = adr_q;
    assign draw_sel    = sel_q;
    assign busy        = busy_q;
    assign frame_done  = fdone_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_enemy_draw_scheduler.sv
// Scoreboard bench for enemy_draw_scheduler: reference job order
// from round-robin rules, monitor pops on draw_start/frame_done.
module tb_enemy_draw_scheduler;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int AW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            frame_start = 1'b0;
    logic [N-1:0]    spawn = '0;
    logic [N*DW-1:0] x_in = '0;
    logic [N*AW-1:0] adr_in = '0;
    logic            draw_start;
    logic [DW-1:0]   draw_x;
    logic [AW-1:0]   draw_adr;
    logic [1:0]      draw_sel;
    logic            draw_done = 1'b0;
    logic            busy;
    logic            frame_done;
    logic [7:0]      overrun_cnt;
`ifdef DRAW_TIMEOUT_EN
    logic            timeout_flag;
`endif

    enemy_draw_scheduler #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .spawn       (spawn),
        .x_in        (x_in),
        .adr_in      (adr_in),
        .draw_start  (draw_start),
        .draw_x      (draw_x),
        .draw_adr    (draw_adr),
        .draw_sel    (draw_sel),
        .draw_done   (draw_done),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun_cnt (overrun_cnt)
`ifdef DRAW_TIMEOUT_EN
        ,
        .timeout_flag(timeout_flag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit fd;
        int sel;
        int x;
        int adr;
        int cyc;
    } ev_t;

    ev_t q[$];
    ev_t me;
    int  cyc = 0;
    int  rr_m = 0;
    int  ovr_m = 0;
    int  n_chk = 0;
    int  n_fail = 0;
    int  eng_delay = 5;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endfunction

    // Monitor: sample #1 after each rising edge, pop and compare.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst_n && draw_start) begin
                if (q.size() == 0 || q[0].fd) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_draw_start: sel %0d at cycle %0d, expected none",
                             draw_sel, cyc);
                end else begin
                    me = q.pop_front();
                    chk("job_sel", 32'(draw_sel), me.sel);
                    chk("job_x", 32'(draw_x), me.x);
                    chk("job_adr", 32'(draw_adr), me.adr);
                    if (me.cyc >= 0) chk("job_cycle", cyc, me.cyc);
                end
            end
            if (rst_n && frame_done) begin
                if (q.size() == 0 || !q[0].fd) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_frame_done: at cycle %0d, expected none",
                             cyc);
                end else begin
                    me = q.pop_front();
                    if (me.cyc >= 0) chk("frame_done_cycle", cyc, me.cyc);
                    rr_m = (rr_m + 1) % N;
                end
            end
        end
    end

    // Engine model: answers eng_delay cycles after each strobe (0 = never).
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cnt = 0;
                draw_done = 1'b0;
            end else if (draw_start) begin
                cnt = eng_delay;
                draw_done = 1'b0;
            end else if (cnt > 0) begin
                cnt--;
                draw_done = (cnt == 0);
            end else begin
                draw_done = 1'b0;
            end
        end
    end

    // Called at a falling edge; pulses frame_start and queues the frame.
    task automatic start_frame(input logic [N-1:0] m, input bit abort);
        int  t;
        bit  first;
        ev_t ev;
        if (abort) begin
            if (q.size() != 0) ovr_m = (ovr_m == 255) ? 255 : ovr_m + 1;
            q.delete();
        end
        spawn = m;
        frame_start = 1'b1;
        t = cyc;
        first = 1'b1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (rr_m + k) % N;
            if (m[j]) begin
                ev.fd  = 1'b0;
                ev.sel = j;
                ev.x   = int'(x_in[j*DW +: DW]);
                ev.adr = int'(adr_in[j*AW +: AW]);
                ev.cyc = first ? t + 2 : -1;
                first  = 1'b0;
                q.push_back(ev);
            end
        end
        ev.fd  = 1'b1;
        ev.sel = 0;
        ev.x   = 0;
        ev.adr = 0;
        ev.cyc = first ? t + 2 : -1;
        q.push_back(ev);
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int b;
        b = budget;
        while (q.size() != 0 && b > 0) begin
            @(negedge clk);
            b--;
        end
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d events outstanding, expected 0",
                     q.size());
            q.delete();
        end
    endtask

    task automatic wait_sel(input int s, input int budget);
        int b;
        b = budget;
        do begin
            @(negedge clk);
            b--;
        end while (!(draw_start && (s < 0 || int'(draw_sel) == s)) && b > 0);
        if (!draw_start) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_sel_timeout: no draw_start on sel %0d, expected one", s);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_draw_start"}, 32'(draw_start), 0);
        chk({tag, "_draw_x"}, 32'(draw_x), 0);
        chk({tag, "_draw_adr"}, 32'(draw_adr), 0);
        chk({tag, "_draw_sel"}, 32'(draw_sel), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
        chk({tag, "_overrun"}, 32'(overrun_cnt), 0);
`ifdef DRAW_TIMEOUT_EN
        chk({tag, "_timeout_flag"}, 32'(timeout_flag), 0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [N-1:0] m;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed frame with fixed positions.
        x_in   = {8'd30, 8'd20, 8'd10};
        adr_in = {16'h0300, 16'h0200, 16'h0100};
        eng_delay = 5;
        start_frame(3'b111, 1'b0);
        chk("busy_during_frame", 32'(busy), 1);
        wait_drain(200);
        @(negedge clk);
        chk("busy_after_frame", 32'(busy), 0);

        // Three back-to-back frames rotate the start slot.
        repeat (3) begin
            start_frame(3'b111, 1'b0);
            wait_drain(200);
            @(negedge clk);
        end

        // Sparse and empty masks.
        start_frame(3'b101, 1'b0);
        wait_drain(200);
        @(negedge clk);
        start_frame(3'b000, 1'b0);
        wait_drain(50);
        @(negedge clk);

        // Abort while waiting on sel 1.
        start_frame(3'b111, 1'b0);
        wait_sel(1, 100);
        @(negedge clk);
        start_frame(3'b111, 1'b1);
        chk("overrun_after_abort", 32'(overrun_cnt), 1);
        wait_drain(200);
        @(negedge clk);

        // Randomized frames with occasional aborts and mid-frame spawn noise.
        for (int f = 0; f < 40; f++) begin
            x_in      = N*DW'($urandom);
            adr_in    = {16'($urandom), 16'($urandom), 16'($urandom)};
            eng_delay = $urandom_range(1, 8);
            m         = N'($urandom_range(0, 7));
            start_frame(m, 1'b0);
            spawn = N'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 12)) @(negedge clk);
                m = N'($urandom_range(0, 7));
                start_frame(m, 1'b1);
                spawn = N'($urandom);
            end
            wait_drain(300);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        chk("overrun_random", 32'(overrun_cnt), ovr_m);

        // Held frame_start: every cycle after the first is an overrun.
        spawn = 3'b111;
        frame_start = 1'b1;
        repeat (299) @(negedge clk);
        start_frame(3'b111, 1'b1);
        ovr_m = 255;
        chk("overrun_saturated", 32'(overrun_cnt), 255);
        wait_drain(200);
        @(negedge clk);

        // Reset mid-job, then restart from slot 0.
        if (rr_m == 0) begin
            start_frame(3'b111, 1'b0);
            wait_drain(200);
            @(negedge clk);
        end
        eng_delay = 6;
        start_frame(3'b111, 1'b0);
        wait_sel(-1, 100);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        q.delete();
        rr_m  = 0;
        ovr_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_frame(3'b111, 1'b0);
        chk("restart_first_sel", 32'(q[0].sel), 0);
        wait_drain(200);
        @(negedge clk);

`ifdef DRAW_TIMEOUT_EN
        // Engine never answers: each job advances after the watchdog.
        eng_delay = 0;
        start_frame(3'b011, 1'b0);
        q[1].cyc = q[0].cyc + 18;
        wait_drain(200);
        @(negedge clk);
        chk("timeout_flag_set", 32'(timeout_flag), 1);
        eng_delay = 5;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
